// File: rtl/nonce_scheduler_if.sv
// Groups the header-load, search-control, hash-core and status signals of the nonce scheduler.
// The master side drives the scheduler's inputs; the slave side is the scheduler itself.
interface nonce_scheduler_if;
  logic         hdr_we;
  logic [4:0]   hdr_waddr;
  logic [31:0]  hdr_wdata;
  logic [31:0]  nonce_first;
  logic [31:0]  nonce_last;
  logic [255:0] target;
  logic         go;
  logic         abort;
  logic         core_start;
  logic [4:0]   core_addr;
  logic         core_rq;
  logic [31:0]  core_data;
  logic         core_rdy;
  logic [255:0] core_hash;
  logic         core_done;
  logic         busy;
  logic         found;
  logic         exhausted;
  logic [31:0]  found_nonce;
  logic [31:0]  hash_count;

  modport master (
    output hdr_we, hdr_waddr, hdr_wdata, nonce_first, nonce_last, target, go, abort,
    output core_addr, core_rq, core_hash, core_done,
    input  core_start, core_data, core_rdy, busy, found, exhausted, found_nonce, hash_count
  );

  modport slave (
    input  hdr_we, hdr_waddr, hdr_wdata, nonce_first, nonce_last, target, go, abort,
    input  core_addr, core_rq, core_hash, core_done,
    output core_start, core_data, core_rdy, busy, found, exhausted, found_nonce, hash_count
  );
endinterface

// File: rtl/nonce_scheduler.sv
// Walks a nonce range, feeding header words plus the current nonce to an external hash core
// and stopping on the first hash at or below the target, or when the range runs out.
module nonce_scheduler (
  input  logic             clk,
  input  logic             rst_n,
  nonce_scheduler_if.slave bus
);
  localparam int HDR_WORDS = 19;

  typedef enum logic [2:0] {IDLE, START, RUN, CHECK, DONE} state_t;

  state_t       state_q, state_d;
  logic [31:0]  header_q [HDR_WORDS];
  logic [31:0]  nonce_q, nonceLast_q, foundNonce_q, hashCount_q, coreData_q;
  logic [255:0] target_q, hash_q;
  logic         found_q, exhausted_q, coreRdy_q, rqPrev_q, donePrev_q;

  logic         busyInt, rqRise, doneRise, hit;
  logic         loadGo, captureHash, setFound, setExhausted, stepNonce, issueRdy, abortNow;
  logic [31:0]  fetchData;

  assign busyInt  = (state_q == START) || (state_q == RUN) || (state_q == CHECK);
  assign rqRise   = bus.core_rq && !rqPrev_q;
  assign doneRise = bus.core_done && !donePrev_q;

  always_comb begin
    state_d      = state_q;
    loadGo       = 1'b0;
    captureHash  = 1'b0;
    setFound     = 1'b0;
    setExhausted = 1'b0;
    stepNonce    = 1'b0;
    issueRdy     = 1'b0;
    abortNow     = 1'b0;
    hit          = (hash_q <= target_q);
    case (state_q)
      IDLE, DONE: begin
        if (bus.go) begin
          loadGo  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bus.abort) begin
          abortNow = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Abort wins over any core edge seen in the same cycle.
        if (bus.abort) begin
          abortNow = 1'b1;
          state_d  = IDLE;
        end else begin
          issueRdy = rqRise;
          if (doneRise) begin
            captureHash = 1'b1;
            state_d     = CHECK;
          end
        end
      end
      CHECK: begin
        if (bus.abort) begin
          abortNow = 1'b1;
          state_d  = IDLE;
        end else if (hit) begin
          setFound = 1'b1;
          state_d  = DONE;
        end else if (nonce_q == nonceLast_q) begin
          setExhausted = 1'b1;
          state_d      = DONE;
        end else begin
          stepNonce = 1'b1;
          state_d   = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word 19 is the live nonce in byte-reversed order; addresses above it read as zero.
  always_comb begin
    fetchData = '0;
    if (bus.core_addr < 5'(HDR_WORDS)) begin
      fetchData = header_q[bus.core_addr];
    end else if (bus.core_addr == 5'(HDR_WORDS)) begin
      fetchData = {nonce_q[7:0], nonce_q[15:8], nonce_q[23:16], nonce_q[31:24]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HDR_WORDS; i++) header_q[i] <= '0;
    end else if (bus.hdr_we && !busyInt && (bus.hdr_waddr < 5'(HDR_WORDS))) begin
      header_q[bus.hdr_waddr] <= bus.hdr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nonce_q      <= '0;
      nonceLast_q  <= '0;
      target_q     <= '0;
      hash_q       <= '0;
      foundNonce_q <= '0;
      hashCount_q  <= '0;
      coreData_q   <= '0;
      found_q      <= 1'b0;
      exhausted_q  <= 1'b0;
      coreRdy_q    <= 1'b0;
      rqPrev_q     <= 1'b0;
      donePrev_q   <= 1'b0;
    end else begin
      rqPrev_q   <= bus.core_rq;
      donePrev_q <= bus.core_done;
      coreRdy_q  <= issueRdy;
      if (issueRdy) coreData_q <= fetchData;
      if (loadGo) begin
        nonce_q      <= bus.nonce_first;
        nonceLast_q  <= bus.nonce_last;
        target_q     <= bus.target;
        found_q      <= 1'b0;
        exhausted_q  <= 1'b0;
        foundNonce_q <= '0;
        hashCount_q  <= '0;
      end
      if (abortNow) begin
        found_q     <= 1'b0;
        exhausted_q <= 1'b0;
      end
      if (captureHash) begin
        hash_q <= bus.core_hash;
        if (hashCount_q != '1) hashCount_q <= hashCount_q + 32'd1;
      end
      if (setFound) begin
        found_q      <= 1'b1;
        foundNonce_q <= nonce_q;
      end
      if (setExhausted) exhausted_q <= 1'b1;
      if (stepNonce) nonce_q <= nonce_q + 32'd1;
    end
  end

  assign bus.core_start  = (state_q == START);
  assign bus.core_rdy    = coreRdy_q;
  assign bus.core_data   = coreData_q;
  assign bus.busy        = busyInt;
  assign bus.found       = found_q;
  assign bus.exhausted   = exhausted_q;
  assign bus.found_nonce = foundNonce_q;
  assign bus.hash_count  = hashCount_q;
endmodule
